// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: button indices, repeat FSM states and default timing for the input conditioner
package input_conditioner_pkg;
  localparam int CLK_HZ = 25_000_000;
  localparam int BTN_LEFT = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_SHOOT = 2;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEF_REPEAT_DELAY = CLK_HZ / 4;
  localparam int DEF_REPEAT_PERIOD = CLK_HZ / 10;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: one button's synchroniser, debounce, press strobe and auto-repeat FSM
module button_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN = 1'b1,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic strobe
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
  logic [1:0] sync;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rpt_cnt, rpt_cnt_nx, term;
  rpt_state_t state, state_nx;
  logic s, flip, rise, fall, rpt_stb;
  assign s = sync[1];
  assign flip = (s != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise = flip && !level;
  assign fall = flip && level;
  assign term = state == DELAY ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      db_cnt <= '0;
      level <= 1'b0;
      strobe <= 1'b0;
      state <= IDLE;
      rpt_cnt <= '0;
    end else begin
      sync <= {sync[0], ACTIVE_HIGH ? pin : !pin};
      db_cnt <= (s == level || flip) ? '0 : db_cnt + 1'b1;
      level <= level ^ flip;
      strobe <= rise || rpt_stb;
      state <= state_nx;
      rpt_cnt <= rpt_cnt_nx;
    end
  end
  // a falling level beats a coinciding terminal count
  always_comb begin
    state_nx = state;
    rpt_cnt_nx = rpt_cnt + 1'b1;
    rpt_stb = 1'b0;
    if (!REPEAT_EN || fall) begin
      state_nx = IDLE;
      rpt_cnt_nx = '0;
    end else if (state == IDLE) begin
      state_nx = rise ? DELAY : IDLE;
      rpt_cnt_nx = '0;
    end else if (rpt_cnt == term) begin
      rpt_stb = 1'b1;
      state_nx = REPEAT;
      rpt_cnt_nx = '0;
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and strobes the raw left/right/shoot buttons
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_BUTTONS = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK = 3'b011,
  parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
  input  logic                 i_clk_25MHz,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_buttons,
  output logic [N_BUTTONS-1:0] o_level,
  output logic [N_BUTTONS-1:0] o_strobe
);
  for (genvar b = 0; b < N_BUTTONS; b++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN(REPEAT_MASK[b]),
      .ACTIVE_HIGH(BUTTON_ACTIVE_HIGH)
    ) u_btn (
      .clk(i_clk_25MHz),
      .rst_n(i_reset),
      .pin(i_buttons[b]),
      .level(o_level[b]),
      .strobe(o_strobe[b])
    );
  end
endmodule
